// File: rtl/lgdst_adspi_pkg.sv
// Shared definitions for the ADRF SPI arbiter: FSM encoding and frame layout constants.
package lgdst_adspi_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_SHIFT = 3'd2,
        ST_HOLD  = 3'd3,
        ST_GAP   = 3'd4
    } state_t;

    localparam int WORD_W_DEF = 24;
    localparam int RW_BIT     = 23;
    localparam int RD_BITS    = 8;

endpackage

// File: rtl/lgdst_adspi_rr_arb.sv
// Two-way round-robin arbiter; the pointer moves only when a grant is accepted.
module lgdst_adspi_rr_arb (
    input  logic       clk,
    input  logic       resync_n,
    input  logic [1:0] valid,
    input  logic       accept,
    output logic [1:0] grant
);

    // last = 1 means requester 1 was granted last, so requester 0 wins a tie
    logic last;

    always_comb begin
        grant = valid;
        if (valid == 2'b11) begin
            grant = last ? 2'b01 : 2'b10;
        end
    end

    always_ff @(posedge clk) begin
        if (!resync_n) begin
            last <= 1'b1;
        end else if (accept && (|valid)) begin
            last <= grant[1];
        end
    end

endmodule

// File: rtl/lgdst_adspi_arb.sv
// Two-requester arbiter driving a 3-wire ADRF SPI port.
// Define LGDST_ADSPI_READBACK_EN to turn sdio around and capture read data on read frames.
module lgdst_adspi_arb
    import lgdst_adspi_pkg::*;
#(
    parameter int CLK_DIV = 4,
    parameter int WORD_W  = WORD_W_DEF
) (
    input  logic              clk,
    input  logic              resync_n,
    input  logic              req0_valid,
    input  logic              req1_valid,
    input  logic [WORD_W-1:0] req0_data,
    input  logic [WORD_W-1:0] req1_data,
    output logic              req0_ready,
    output logic              req1_ready,
    output logic              rsp_valid,
    output logic              rsp_id,
    output logic [7:0]        rsp_rdata,
    output logic              busy,
    output logic              ad_spi_cs,
    output logic              ad_spi_sclk,
    output logic              ad_spi_sdo,
    output logic              ad_spi_sdo_oe,
    input  logic              ad_spi_sdi
);

`ifdef LGDST_ADSPI_READBACK_EN
    localparam bit RB_EN = 1'b1;
`else
    localparam bit RB_EN = 1'b0;
`endif

    localparam int              PH_W       = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [PH_W-1:0] PH_LAST    = PH_W'(CLK_DIV - 1);
    localparam logic [4:0]      BIT_LAST   = 5'(WORD_W - 1);
    localparam logic [4:0]      BIT_RD_MSB = 5'(WORD_W - RD_BITS);

    state_t            state, state_nxt;
    logic [PH_W-1:0]   ph, ph_nxt;
    logic [4:0]        bit_cnt, bit_cnt_nxt;
    logic              sclk, sclk_nxt;
    logic              cs, cs_nxt;
    logic              oe, oe_nxt;
    logic [WORD_W-1:0] sh, sh_nxt;
    logic              rd, rd_nxt;
    logic              cur_id, cur_id_nxt;
    logic [7:0]        rsh, rsh_nxt;
    logic              rv, rv_nxt;
    logic              rid, rid_nxt;
    logic [7:0]        rdat, rdat_nxt;

    logic [1:0] grant;
    logic       accept;
    logic       phase_end;

    assign accept = (state == ST_IDLE) && resync_n;

    lgdst_adspi_rr_arb u_rr (
        .clk      (clk),
        .resync_n (resync_n),
        .valid    ({req1_valid, req0_valid}),
        .accept   (accept),
        .grant    (grant)
    );

    assign req0_ready = grant[0] & accept;
    assign req1_ready = grant[1] & accept;
    assign phase_end  = (ph == PH_LAST);

    always_comb begin
        state_nxt   = state;
        ph_nxt      = ph;
        bit_cnt_nxt = bit_cnt;
        sclk_nxt    = sclk;
        cs_nxt      = cs;
        oe_nxt      = oe;
        sh_nxt      = sh;
        rd_nxt      = rd;
        cur_id_nxt  = cur_id;
        rsh_nxt     = rsh;
        rv_nxt      = 1'b0;
        rid_nxt     = rid;
        rdat_nxt    = rdat;
        case (state)
            ST_IDLE: begin
                if (|grant) begin
                    state_nxt   = ST_SETUP;
                    ph_nxt      = '0;
                    bit_cnt_nxt = '0;
                    cs_nxt      = 1'b0;
                    sclk_nxt    = 1'b0;
                    oe_nxt      = 1'b1;
                    sh_nxt      = grant[1] ? req1_data : req0_data;
                    rd_nxt      = grant[1] ? req1_data[RW_BIT] : req0_data[RW_BIT];
                    cur_id_nxt  = grant[1];
                    rsh_nxt     = '0;
                end
            end
            ST_SETUP: begin
                ph_nxt = ph + 1'b1;
                if (phase_end) begin
                    state_nxt = ST_SHIFT;
                    ph_nxt    = '0;
                end
            end
            ST_SHIFT: begin
                ph_nxt = ph + 1'b1;
                if (phase_end) begin
                    ph_nxt = '0;
                    if (!sclk) begin
                        sclk_nxt = 1'b1;
                    end else begin
                        // end of a high phase: capture readback, then fall into the next bit
                        if (RB_EN && rd && (bit_cnt >= BIT_RD_MSB)) begin
                            rsh_nxt = {rsh[6:0], ad_spi_sdi};
                        end
                        sclk_nxt = 1'b0;
                        if (bit_cnt == BIT_LAST) begin
                            state_nxt   = ST_HOLD;
                            bit_cnt_nxt = '0;
                            oe_nxt      = 1'b0;
                        end else begin
                            bit_cnt_nxt = bit_cnt + 1'b1;
                            sh_nxt      = sh << 1;
                            if (RB_EN && rd && ((bit_cnt + 1'b1) == BIT_RD_MSB)) begin
                                oe_nxt = 1'b0;
                            end
                        end
                    end
                end
            end
            ST_HOLD: begin
                ph_nxt = ph + 1'b1;
                if (phase_end) begin
                    state_nxt = ST_GAP;
                    ph_nxt    = '0;
                    cs_nxt    = 1'b1;
                end
            end
            ST_GAP: begin
                ph_nxt = ph + 1'b1;
                if (phase_end) begin
                    state_nxt = ST_IDLE;
                    ph_nxt    = '0;
                    rv_nxt    = 1'b1;
                    rid_nxt   = cur_id;
                    rdat_nxt  = (RB_EN && rd) ? rsh : 8'h00;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
                cs_nxt    = 1'b1;
                sclk_nxt  = 1'b0;
                oe_nxt    = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resync_n) begin
            state   <= ST_IDLE;
            ph      <= '0;
            bit_cnt <= '0;
            sclk    <= 1'b0;
            cs      <= 1'b1;
            oe      <= 1'b0;
            sh      <= '0;
            rd      <= 1'b0;
            cur_id  <= 1'b0;
            rsh     <= '0;
            rv      <= 1'b0;
            rid     <= 1'b0;
            rdat    <= '0;
        end else begin
            state   <= state_nxt;
            ph      <= ph_nxt;
            bit_cnt <= bit_cnt_nxt;
            sclk    <= sclk_nxt;
            cs      <= cs_nxt;
            oe      <= oe_nxt;
            sh      <= sh_nxt;
            rd      <= rd_nxt;
            cur_id  <= cur_id_nxt;
            rsh     <= rsh_nxt;
            rv      <= rv_nxt;
            rid     <= rid_nxt;
            rdat    <= rdat_nxt;
        end
    end

    assign busy          = (state != ST_IDLE);
    assign ad_spi_cs     = cs;
    assign ad_spi_sclk   = sclk;
    assign ad_spi_sdo    = sh[WORD_W-1];
    assign ad_spi_sdo_oe = oe;
    assign rsp_valid     = rv;
    assign rsp_id        = rid;
    assign rsp_rdata     = rdat;

endmodule
